// File: rtl/ysyx_25030081_pkg.sv
// Shared constants for the memory path: FSM state encoding, PMEM window, fault check.
// The PMEM window is also what the core's reset PC is derived from.
package ysyx_25030081_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [31:0] PMEM_BASE = 32'h8000_0000;
  localparam logic [31:0] PMEM_SIZE = 32'h0800_0000;

  // Subtracting before comparing keeps the upper bound correct when base+size would wrap.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
    return (addr[1:0] != 2'b00) || (addr < base) || ((addr - base) >= size);
  endfunction

endpackage

// File: rtl/ysyx_25030081_pmem_pkg.sv
// Simulated physical memory behind pmem_read / pmem_write: sparse word store plus call counters.
// Stands where the C-side memory of the simulator sits, with the same call signatures.
package ysyx_25030081_pmem_pkg;

  logic [31:0] mem [int unsigned];
  int unsigned rd_calls = 0;
  int unsigned wr_calls = 0;

  function automatic int pmem_read(input int addr);
    int unsigned w;
    w = unsigned'(addr) >> 2;
    rd_calls++;
    return mem.exists(w) ? int'(mem[w]) : 0;
  endfunction

  function automatic void pmem_write(input int addr, input int data, input byte mask);
    int unsigned w;
    logic [31:0] word;
    w = unsigned'(addr) >> 2;
    word = mem.exists(w) ? mem[w] : 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) word[8*i +: 8] = data[8*i +: 8];
    end
    mem[w] = word;
    wr_calls++;
  endfunction

endpackage

// File: rtl/ysyx_25030081_sram_if.sv
// Request/response channel between the fetch or load/store unit (master) and the memory responder (slave).
interface ysyx_25030081_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_wen;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [3:0]            req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ysyx_25030081_lat_cnt.sv
// Loadable down-counter that parks at zero; zero is a decode of the count register.
// Latency: load takes effect on the next edge. No backpressure.
module ysyx_25030081_lat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ysyx_25030081_sram.sv
// Memory responder: one access at a time, rsp_valid LATENCY cycles after the request handshake.
// Backpressure: a pending response holds stable until rsp_ready; no request is taken meanwhile.
module ysyx_25030081_sram
  import ysyx_25030081_pkg::*, ysyx_25030081_pmem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] BASE       = PMEM_BASE,
  parameter logic [31:0] SIZE       = PMEM_SIZE
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_25030081_sram_if.slave bus
);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic                  cnt_zero;
  logic                  accept;
  logic                  complete;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [3:0]            wmask_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [31:0]           addr32;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign complete = (state == WAIT) && cnt_zero;
  assign addr32   = 32'(addr_q);

  ysyx_25030081_lat_cnt #(.WIDTH(8)) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (8'(LATENCY - 1)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = WAIT;
      WAIT:    if (cnt_zero)      state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode only the state register, keeping them free of input paths.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= 4'b0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      wen_q   <= bus.req_wen;
      wdata_q <= bus.req_wdata;
      wmask_q <= bus.req_wmask;
    end
  end

  // The memory is touched only on the completion edge, so a reset earlier in WAIT drops the access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (complete) begin
      if (addr_fault(addr32, BASE, SIZE)) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else if (wen_q) begin
        pmem_write(int'(addr32), int'(wdata_q), {4'b0, wmask_q});
        rdata_q <= '0;
        err_q   <= 1'b0;
      end else begin
        rdata_q <= DATA_WIDTH'(pmem_read(int'(addr32)));
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25030081_sram.sv
// Bench: three responders (LATENCY 1, 3, 4) on one clock, checked against a word-array memory model.
module tb_ysyx_25030081_sram;

  localparam int LATS [3] = '{1, 3, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [3];
  logic        req_wen   [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_wmask [3];
  logic        rsp_ready [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int total = 0;
  int bad   = 0;

  logic [31:0] mdl [int unsigned];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ysyx_25030081_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.req_valid = req_valid[g];
    assign bus.req_wen   = req_wen[g];
    assign bus.req_addr  = req_addr[g];
    assign bus.req_wdata = req_wdata[g];
    assign bus.req_wmask = req_wmask[g];
    assign bus.rsp_ready = rsp_ready[g];
    assign req_ready[g]  = bus.req_ready;
    assign rsp_valid[g]  = bus.rsp_valid;
    assign rsp_rdata[g]  = bus.rsp_rdata;
    assign rsp_err[g]    = bus.rsp_err;

    ysyx_25030081_sram #(.LATENCY(LATS[g])) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h8000_0000) || (a > 32'h87FF_FFFF);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    return mdl.exists(a / 4) ? mdl[a / 4] : 32'h0;
  endfunction

  function automatic void m_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = m_rd(a);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) w[8*i +: 8] = d[8*i +: 8];
    end
    mdl[a / 4] = w;
  endfunction

  // Called at #1 after an edge with responder d idle; returns at #1 after it is idle again.
  task automatic xact(input int d, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wmask, input int stall);
    int unsigned rd0, wr0;
    int          c;
    logic        exp_e;
    logic [31:0] exp_d;
    exp_e = m_err(addr);
    exp_d = (!exp_e && !wen) ? m_rd(addr) : 32'h0;
    rd0 = ysyx_25030081_pmem_pkg::rd_calls;
    wr0 = ysyx_25030081_pmem_pkg::wr_calls;
    chk("idle_req_ready", req_ready[d], 1);
    req_valid[d] = 1'b1; req_wen[d] = wen; req_addr[d] = addr;
    req_wdata[d] = wdata; req_wmask[d] = wmask;
    rsp_ready[d] = (stall == 0);
    @(posedge clk); #1;
    // Junk on the request channel while busy must be ignored.
    req_valid[d] = 1'($urandom_range(0, 1));
    req_wen[d]   = 1'($urandom_range(0, 1));
    req_addr[d]  = $urandom();
    req_wdata[d] = $urandom();
    c = 0;
    while (!rsp_valid[d] && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    chk("latency", c, LATS[d]);
    if (!exp_e && wen) m_wr(addr, wdata, wmask);
    chk("rd_calls", ysyx_25030081_pmem_pkg::rd_calls - rd0, (!exp_e && !wen) ? 1 : 0);
    chk("wr_calls", ysyx_25030081_pmem_pkg::wr_calls - wr0, (!exp_e && wen) ? 1 : 0);
    chk("rdata", rsp_rdata[d], exp_d);
    chk("err", rsp_err[d], exp_e);
    chk("busy_req_ready", req_ready[d], 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid[d], 1);
      chk("hold_rdata", rsp_rdata[d], exp_d);
      chk("hold_err", rsp_err[d], exp_e);
      chk("hold_req_ready", req_ready[d], 0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
    chk("post_valid", rsp_valid[d], 0);
    chk("post_req_ready", req_ready[d], 1);
    chk("post_rd_calls", ysyx_25030081_pmem_pkg::rd_calls - rd0, (!exp_e && !wen) ? 1 : 0);
  endtask

  task automatic b2b(input int d, input int n);
    int          issued = 0, got = 0, last_hs = 0, c = 0;
    logic [31:0] exp_q [$];
    req_valid[d] = 1'b1; req_wen[d] = 1'b0; req_addr[d] = 32'h8000_0000; rsp_ready[d] = 1'b1;
    while ((issued < n || got < n) && c < 400) begin
      logic hs;
      hs = req_valid[d] && req_ready[d];
      if (rsp_valid[d]) begin
        if (exp_q.size() == 0) chk("b2b_spurious", 1, 0);
        else chk("b2b_rdata", rsp_rdata[d], exp_q.pop_front());
        chk("b2b_err", rsp_err[d], 0);
        got++;
      end
      if (hs) exp_q.push_back(m_rd(req_addr[d]));
      @(posedge clk); #1;
      c++;
      if (hs) begin
        if (issued > 0) chk("b2b_gap", c - last_hs, LATS[d] + 2);
        last_hs = c;
        issued++;
        if (issued == n) req_valid[d] = 1'b0;
        else req_addr[d] = req_addr[d] + 32'd4;
      end
    end
    chk("b2b_count", got, n);
    rsp_ready[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int unsigned wr0, rd0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_wmask[d] = '0; rsp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_req_ready", req_ready[d], 1);
      chk("rst_rsp_valid", rsp_valid[d], 0);
      chk("rst_rdata", rsp_rdata[d], 0);
      chk("rst_err", rsp_err[d], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // LATENCY=1: preload then read the first instruction word.
    xact(0, 1'b1, 32'h8000_0000, 32'h0010_0073, 4'hF, 0);
    xact(0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0);

    // LATENCY=3: partial write keeps the upper bytes.
    xact(1, 1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF, 0);
    xact(1, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b0011, 0);
    xact(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 0);
    xact(1, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 0);

    // Faults and range edges.
    xact(0, 1'b0, 32'h8000_0002, 32'h0, 4'h0, 0);
    xact(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0);
    xact(2, 1'b1, 32'h8800_0000, 32'hA5A5_A5A5, 4'hF, 0);
    xact(2, 1'b1, 32'h87FF_FFFC, 32'hCAFE_F00D, 4'hF, 0);
    xact(2, 1'b0, 32'h87FF_FFFC, 32'h0, 4'h0, 0);

    // Response backpressure.
    xact(1, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 10);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
        1:       a = 32'h7FFF_FFFC - 32'($urandom_range(0, 3) * 4);
        2:       a = 32'h8800_0000 + 32'($urandom_range(0, 3) * 4);
        3:       a = 32'hFFFF_FFF0;
        4:       a = 32'h87FF_FFFC;
        default: a = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4);
      endcase
      xact($urandom_range(0, 2), 1'($urandom_range(0, 1)), a, $urandom(),
           4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    // Reset mid-WAIT on LATENCY=4 drops a write; give rsp_rdata a nonzero value first.
    xact(2, 1'b1, 32'h8000_0000, 32'h0010_0073, 4'hF, 0);
    xact(2, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0);
    wr0 = ysyx_25030081_pmem_pkg::wr_calls;
    rd0 = ysyx_25030081_pmem_pkg::rd_calls;
    req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_addr[2] = 32'h8000_0000;
    req_wdata[2] = 32'h5555_AAAA; req_wmask[2] = 4'hF;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    chk("wait_req_ready", req_ready[2], 0);
    rst = 1'b1;
    #1;
    chk("arst_req_ready", req_ready[2], 1);
    chk("arst_rsp_valid", rsp_valid[2], 0);
    chk("arst_rdata", rsp_rdata[2], 0);
    chk("arst_err", rsp_err[2], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("arst_no_write", ysyx_25030081_pmem_pkg::wr_calls - wr0, 0);
    chk("arst_no_read", ysyx_25030081_pmem_pkg::rd_calls - rd0, 0);
    chk("arst_rsp_valid_after", rsp_valid[2], 0);
    xact(2, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0);

    // Back-to-back reads with req_valid held.
    b2b(0, 3);
    b2b(1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
